sys_front_end: RTL and testbench

SYS_FRONT_END -- requirements
Module: sys_front_end

---
 rtl/sys_fe_pkg.sv | 27 ++
 rtl/sys_front_end_if.sv | 30 +++
 rtl/debounce.sv | 47 ++++
 rtl/sys_front_end.sv | 111 +++++++++++
 tb/tb_sys_front_end.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sys_fe_pkg.sv
// sys_fe_pkg: shared definitions for the board front-end that sits between
// the push buttons / slide switches and the single-cycle CPU datapath.
//   fe_state_e    : front-end FSM encoding, also shown on the LEDs
//   NUM_BTN/BTN_* : debounced button lanes and their indices
//   SEL_MAX       : last display-select value before wrapping to 0
//   PC_ALIGN_MASK : clears PC[1:0] so loaded PCs are word aligned
package sys_fe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } fe_state_e;

  localparam int NUM_BTN  = 3;
  localparam int BTN_STEP = 0;
  localparam int BTN_LOAD = 1;
  localparam int BTN_SEL  = 2;

  localparam logic [2:0] SEL_MAX       = 3'd7;
  localparam logic [7:0] PC_ALIGN_MASK = 8'hFC;

  function automatic logic [2:0] sel_next(input logic [2:0] s);
    return (s == SEL_MAX) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/sys_front_end_if.sv
// sys_front_end_if: board-side inputs and CPU-side outputs of the front-end.
//   master : board / stimulus side (drives buttons and switches)
//   slave  : the front-end itself
//   btn_step, btn_load, btn_sel : raw bouncy push buttons
//   sw_run, sw_pc[7:0]          : slide switches
//   cpu_tick, cpu_load          : CPU clock enable and PC-load strobe
//   cpu_pc_val, cpu_output_sel  : CPU PC load value and display select
//   fe_state[1:0]               : FSM state for LEDs
interface sys_front_end_if;
  logic       btn_step;
  logic       btn_load;
  logic       btn_sel;
  logic       sw_run;
  logic [7:0] sw_pc;
  logic       cpu_tick;
  logic       cpu_load;
  logic [7:0] cpu_pc_val;
  logic [7:0] cpu_output_sel;
  logic [1:0] fe_state;

  modport master (
    output btn_step, btn_load, btn_sel, sw_run, sw_pc,
    input  cpu_tick, cpu_load, cpu_pc_val, cpu_output_sel, fe_state
  );

  modport slave (
    input  btn_step, btn_load, btn_sel, sw_run, sw_pc,
    output cpu_tick, cpu_load, cpu_pc_val, cpu_output_sel, fe_state
  );
endinterface

// File: rtl/debounce.sv
// debounce: one push-button lane.
//   clk, rst : clock, async active-high reset
//   btn_raw  : raw button level
//   rise     : one-cycle pulse on an accepted 0->1 level change
// The raw level goes through a 2-flop synchroniser; the synchronised level
// replaces the stored level once it has differed for DB_CYCLES consecutive
// cycles. rise is registered on the same edge the stable level flips, i.e.
// DB_CYCLES+2 edges after a clean raw change, so the consumer acts on it at
// edge DB_CYCLES+3.
module debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      rise   <= 1'b0;
      if (sync_q[1] != stable_q) begin
        // DB_CYCLES-th consecutive differing sample: accept the new level
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
          rise     <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/sys_front_end.sv
// sys_front_end: debounces the step/load/select buttons, synchronises the
// run switch and generates the CPU clock enable, PC load and display select.
//   SYS_clk, SYS_reset : clock, async active-high reset
//   bus (slave)        : buttons/switches in, cpu_* and fe_state out
// All outputs come straight from flops.
module sys_front_end
  import sys_fe_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV   = 8
) (
  input  logic           SYS_clk,
  input  logic           SYS_reset,
  sys_front_end_if.slave bus
);
  localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

  logic [NUM_BTN-1:0] btn_raw, btn_rise;
  logic [1:0]         run_sync;
  logic               run_s;

  fe_state_e  state_q, state_d;
  logic [7:0] div_q, div_d, pc_q, pc_d;
  logic       tick_q, tick_d, load_q, load_d, pend_q, pend_d;
  logic [2:0] sel_q;
  logic       load_req, go_load;

  assign btn_raw = {bus.btn_sel, bus.btn_load, bus.btn_step};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (SYS_clk),
      .rst    (SYS_reset),
      .btn_raw(btn_raw[i]),
      .rise   (btn_rise[i])
    );
  end

  assign run_s = run_sync[1];

  // A load that would land right after a tick is held one cycle so that
  // cpu_tick is never high two cycles in a row.
  assign load_req = btn_rise[BTN_LOAD] | pend_q;
  assign go_load  = load_req & ~tick_q;
  assign pend_d   = load_req & tick_q;

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    tick_d  = 1'b0;
    load_d  = 1'b0;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        // load > run > step; a step rising alongside a load is dropped
        if (load_req) begin
          if (go_load) state_d = LOAD;
        end else if (run_s) begin
          state_d = RUN;
        end else if (btn_rise[BTN_STEP]) begin
          tick_d = 1'b1;
        end
      end
      RUN: begin
        if (go_load) begin
          state_d = LOAD;
        end else if (!run_s) begin
          state_d = IDLE;
        end else begin
          div_d  = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
          tick_d = (div_d == DIV_LAST);
        end
      end
      LOAD:    state_d = run_s ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) begin
      tick_d = 1'b1;
      load_d = 1'b1;
      pc_d   = bus.sw_pc & PC_ALIGN_MASK;
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      run_sync <= '0;
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= 1'b0;
      load_q   <= 1'b0;
      pc_q     <= '0;
      pend_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      run_sync <= {run_sync[0], bus.sw_run};
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      load_q   <= load_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      if (btn_rise[BTN_SEL]) sel_q <= sel_next(sel_q);
    end
  end

  assign bus.cpu_tick       = tick_q;
  assign bus.cpu_load       = load_q;
  assign bus.cpu_pc_val     = pc_q;
  assign bus.cpu_output_sel = {5'b0, sel_q};
  assign bus.fe_state       = state_q;
endmodule

// File: tb/tb_sys_front_end.sv
// tb_sys_front_end: directed checks of sys_front_end with DB_CYCLES=4,
// RUN_DIV=8. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so "edge k" below counts edges after the
// input change.
module tb_sys_front_end;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sys_front_end_if bus ();

  sys_front_end #(.DB_CYCLES(4), .RUN_DIV(8)) dut (
    .SYS_clk  (clk),
    .SYS_reset(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, first;
    logic prev;
    bus.btn_step = 1'b0;
    bus.btn_load = 1'b0;
    bus.btn_sel  = 1'b0;
    bus.sw_run   = 1'b0;
    bus.sw_pc    = 8'h00;

    // reset state
    repeat (3) cyc();
    check("rst_tick", {7'b0, bus.cpu_tick}, 8'h00);
    check("rst_load", {7'b0, bus.cpu_load}, 8'h00);
    check("rst_pc", bus.cpu_pc_val, 8'h00);
    check("rst_sel", bus.cpu_output_sel, 8'h00);
    check("rst_state", {6'b0, bus.fe_state}, 8'h00);
    rst = 1'b0;

    // bouncy step: 1,1,0 then clean rise held 10 cycles -> one tick at edge 7
    bus.btn_step = 1'b1; cyc(); cyc();
    bus.btn_step = 1'b0; cyc();
    bus.btn_step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("step_tick", {7'b0, bus.cpu_tick}, (k == 7) ? 8'h01 : 8'h00);
      check("step_load", {7'b0, bus.cpu_load}, 8'h00);
    end
    bus.btn_step = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("step_release_tick", {7'b0, bus.cpu_tick}, 8'h00);
    end

    // free run for 40 cycles: first tick at edge 10, 5 ticks total, then IDLE
    ticks = 0; first = 0; prev = 1'b0;
    bus.sw_run = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      if (bus.cpu_tick) begin
        ticks++;
        if (first == 0) first = k;
      end
      check("run_no_back2back", {7'b0, bus.cpu_tick & prev}, 8'h00);
      prev = bus.cpu_tick;
      if (k == 20) check("run_state", {6'b0, bus.fe_state}, 8'h01);
      if (k == 40) bus.sw_run = 1'b0;
    end
    check("run_first_tick", 8'(first), 8'd10);
    check("run_tick_count", 8'(ticks), 8'd5);
    check("run_exit_state", {6'b0, bus.fe_state}, 8'h00);

    // load with sw_pc=27 -> one LOAD cycle at edge 7, pc=24, back to IDLE
    bus.sw_pc = 8'h27;
    bus.btn_load = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("load_tick", {7'b0, bus.cpu_tick}, (k == 7) ? 8'h01 : 8'h00);
      check("load_load", {7'b0, bus.cpu_load}, (k == 7) ? 8'h01 : 8'h00);
      if (k == 7) begin
        check("load_pc", bus.cpu_pc_val, 8'h24);
        check("load_state", {6'b0, bus.fe_state}, 8'h02);
      end
      if (k == 8) begin
        check("load_exit_state", {6'b0, bus.fe_state}, 8'h00);
        check("load_pc_hold", bus.cpu_pc_val, 8'h24);
      end
    end
    bus.btn_load = 1'b0;
    repeat (10) cyc();

    // step and load together: only the LOAD tick, pc aligned FF->FC
    bus.sw_pc = 8'hFF;
    bus.btn_step = 1'b1;
    bus.btn_load = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("both_tick", {7'b0, bus.cpu_tick}, (k == 7) ? 8'h01 : 8'h00);
      check("both_load", {7'b0, bus.cpu_load}, (k == 7) ? 8'h01 : 8'h00);
      if (k == 7) check("both_pc", bus.cpu_pc_val, 8'hFC);
    end
    bus.btn_step = 1'b0;
    bus.btn_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("both_no_step_tick", {7'b0, bus.cpu_tick}, 8'h00);
    end

    // 9 select presses -> 1..7,0,1
    for (int i = 1; i <= 9; i++) begin
      bus.btn_sel = 1'b1;
      repeat (8) cyc();
      bus.btn_sel = 1'b0;
      repeat (8) cyc();
      check("sel_value", bus.cpu_output_sel, 8'(i % 8));
    end

    // reset inside the LOAD cycle: outputs drop before the next edge
    bus.btn_load = 1'b1;
    repeat (7) cyc();
    check("rl_pre_load", {7'b0, bus.cpu_load}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("rl_load", {7'b0, bus.cpu_load}, 8'h00);
    check("rl_tick", {7'b0, bus.cpu_tick}, 8'h00);
    check("rl_pc", bus.cpu_pc_val, 8'h00);
    check("rl_sel", bus.cpu_output_sel, 8'h00);
    check("rl_state", {6'b0, bus.fe_state}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // held button after release: full debounce again -> LOAD at edge 7
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("rl_relaunch_tick", {7'b0, bus.cpu_tick}, (k == 7) ? 8'h01 : 8'h00);
      check("rl_relaunch_load", {7'b0, bus.cpu_load}, (k == 7) ? 8'h01 : 8'h00);
      if (k == 7) check("rl_relaunch_pc", bus.cpu_pc_val, 8'hFC);
    end
    bus.btn_load = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
